// File: rtl/core_pipe_pkg.sv
// Shared types for the core pipeline registers: the EX->MEM bundle layout,
// the datapath widths it is built from, and the skid-buffer state encoding.
package core_pipe_pkg;

    localparam int WIDTH      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int RSRC_W     = 2;

    // Control fields first, then datapath fields.
    typedef struct packed {
        logic                  reg_write;
        logic                  mem_write;
        logic                  jump;
        logic                  jump_reg;
        logic                  branch;
        logic [RSRC_W-1:0]     result_src;
        logic [WIDTH-1:0]      alu_result;
        logic [WIDTH-1:0]      write_data;
        logic [WIDTH-1:0]      imm_ext;
        logic [WIDTH-1:0]      pc_plus4;
        logic [REG_ADDR_W-1:0] rd;
    } exmem_bundle_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One enable-load register holding a full EX->MEM bundle, cleared
// asynchronously on reset.
module pipe_slot
    import core_pipe_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  exmem_bundle_t d_i,
    output exmem_bundle_t q_o
);

    exmem_bundle_t slot_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q <= '0;
        end else if (en_i) begin
            slot_q <= d_i;
        end
    end

    assign q_o = slot_q;

endmodule

// File: rtl/exmem_pipe_stage.sv
// EX->MEM pipeline stage with valid/ready handshake, flush and saturating stall
// counter. Define EXMEM_SKID_EN to add a skid slot and a registered ReadyE.
module exmem_pipe_stage #(
    // Must match the widths baked into core_pipe_pkg::exmem_bundle_t.
    parameter int WIDTH      = core_pipe_pkg::WIDTH,
    parameter int REG_ADDR_W = core_pipe_pkg::REG_ADDR_W,
    parameter int RSRC_W     = core_pipe_pkg::RSRC_W,
    parameter int CNT_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ValidE,
    output logic                  ReadyE,
    input  logic                  FlushM,
    input  logic                  RegWriteE,
    input  logic                  MemWriteE,
    input  logic                  JumpE,
    input  logic                  JumpRegE,
    input  logic                  BranchE,
    input  logic [RSRC_W-1:0]     ResultSrcE,
    input  logic [WIDTH-1:0]      AluResultE,
    input  logic [WIDTH-1:0]      WriteDataE,
    input  logic [WIDTH-1:0]      ImmExtE,
    input  logic [WIDTH-1:0]      PCPlus4E,
    input  logic [REG_ADDR_W-1:0] RdE,
    output logic                  ValidM,
    input  logic                  ReadyM,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic                  JumpM,
    output logic                  JumpRegM,
    output logic                  BranchM,
    output logic [RSRC_W-1:0]     ResultSrcM,
    output logic [WIDTH-1:0]      AluResultM,
    output logic [WIDTH-1:0]      WriteDataM,
    output logic [WIDTH-1:0]      ImmExtM,
    output logic [WIDTH-1:0]      PCPlus4M,
    output logic [REG_ADDR_W-1:0] RdM,
    output logic [CNT_W-1:0]      StallCnt
);
    import core_pipe_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    exmem_bundle_t in_bun;
    exmem_bundle_t main_d;
    exmem_bundle_t main_q;
    logic          main_en;
    logic          up_xfer;
    logic          valid_m;
    logic [CNT_W-1:0] stall_cnt_q;

    assign in_bun = '{
        reg_write:  RegWriteE,
        mem_write:  MemWriteE,
        jump:       JumpE,
        jump_reg:   JumpRegE,
        branch:     BranchE,
        result_src: ResultSrcE,
        alu_result: AluResultE,
        write_data: WriteDataE,
        imm_ext:    ImmExtE,
        pc_plus4:   PCPlus4E,
        rd:         RdE
    };

`ifdef EXMEM_SKID_EN
    skid_state_e   state_q;
    logic          ready_q;
    logic          skid_en;
    exmem_bundle_t skid_q;

    assign ReadyE  = ready_q;
    assign valid_m = (state_q != SKID_EMPTY);
    assign up_xfer = ValidE && ready_q;

    // Skid catches the bundle accepted while main is stalled.
    assign skid_en = !FlushM && up_xfer && (state_q == SKID_ONE) && !ReadyM;
    assign main_en = !FlushM && (((state_q == SKID_EMPTY) && up_xfer)
                              || ((state_q == SKID_ONE) && up_xfer && ReadyM)
                              || ((state_q == SKID_FULL) && ReadyM));
    assign main_d  = (state_q == SKID_FULL) ? skid_q : in_bun;

    pipe_slot u_skid_slot (
        .clk_i (CLK),
        .rst_i (RST),
        .en_i  (skid_en),
        .d_i   (in_bun),
        .q_o   (skid_q)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= SKID_EMPTY;
            ready_q <= 1'b1;
        end else if (FlushM) begin
            state_q <= SKID_EMPTY;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (up_xfer) begin
                        state_q <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (up_xfer && !ReadyM) begin
                        state_q <= SKID_FULL;
                        ready_q <= 1'b0;
                    end else if (!up_xfer && ReadyM) begin
                        state_q <= SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (ReadyM) begin
                        state_q <= SKID_ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= SKID_EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
`else
    logic valid_q;

    assign ReadyE  = !valid_q || ReadyM;
    assign valid_m = valid_q;
    assign up_xfer = ValidE && ReadyE;
    assign main_en = !FlushM && up_xfer;
    assign main_d  = in_bun;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= 1'b0;
        end else if (FlushM) begin
            valid_q <= 1'b0;
        end else if (up_xfer) begin
            valid_q <= 1'b1;
        end else if (ReadyM) begin
            valid_q <= 1'b0;
        end
    end
`endif

    pipe_slot u_main_slot (
        .clk_i (CLK),
        .rst_i (RST),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else if (valid_m && !ReadyM && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    // A bubble must never write state or redirect the PC.
    assign ValidM     = valid_m;
    assign RegWriteM  = main_q.reg_write & valid_m;
    assign MemWriteM  = main_q.mem_write & valid_m;
    assign JumpM      = main_q.jump      & valid_m;
    assign JumpRegM   = main_q.jump_reg  & valid_m;
    assign BranchM    = main_q.branch    & valid_m;
    assign ResultSrcM = main_q.result_src;
    assign AluResultM = main_q.alu_result;
    assign WriteDataM = main_q.write_data;
    assign ImmExtM    = main_q.imm_ext;
    assign PCPlus4M   = main_q.pc_plus4;
    assign RdM        = main_q.rd;
    assign StallCnt   = stall_cnt_q;

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// Scoreboard bench for exmem_pipe_stage; expected bundles are queued on
// upstream transfers and checked on downstream transfers.
module tb_exmem_pipe_stage;

    localparam int CNT_W = 4;
`ifdef EXMEM_SKID_EN
    localparam int EXTRA_ACCEPT = 1;
`else
    localparam int EXTRA_ACCEPT = 0;
`endif

    typedef struct packed {
        logic [4:0]  ctl;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] imm;
        logic [31:0] pc;
    } tb_bun_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ValidE = 1'b0, ReadyE, FlushM = 1'b0;
    logic        RegWriteE = 1'b0, MemWriteE = 1'b0, JumpE = 1'b0, JumpRegE = 1'b0, BranchE = 1'b0;
    logic [1:0]  ResultSrcE = '0;
    logic [31:0] AluResultE = '0, WriteDataE = '0, ImmExtE = '0, PCPlus4E = '0;
    logic [4:0]  RdE = '0;
    logic        ValidM, ReadyM = 1'b1;
    logic        RegWriteM, MemWriteM, JumpM, JumpRegM, BranchM;
    logic [1:0]  ResultSrcM;
    logic [31:0] AluResultM, WriteDataM, ImmExtM, PCPlus4M;
    logic [4:0]  RdM;
    logic [CNT_W-1:0] StallCnt;

    int n_cmp = 0;
    int n_err = 0;
    int n_up  = 0;
    tb_bun_t sb[$];
    logic         hold_prev = 1'b0;
    logic [140:0] prev_out  = '0;

    exmem_pipe_stage #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ValidE(ValidE), .ReadyE(ReadyE), .FlushM(FlushM),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .JumpRegE(JumpRegE),
        .BranchE(BranchE), .ResultSrcE(ResultSrcE), .AluResultE(AluResultE),
        .WriteDataE(WriteDataE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .RdE(RdE),
        .ValidM(ValidM), .ReadyM(ReadyM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .JumpM(JumpM), .JumpRegM(JumpRegM), .BranchM(BranchM), .ResultSrcM(ResultSrcM),
        .AluResultM(AluResultM), .WriteDataM(WriteDataM), .ImmExtM(ImmExtM),
        .PCPlus4M(PCPlus4M), .RdM(RdM), .StallCnt(StallCnt)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic tb_bun_t e_bun();
        return {RegWriteE, MemWriteE, JumpE, JumpRegE, BranchE, ResultSrcE, RdE,
                AluResultE, WriteDataE, ImmExtE, PCPlus4E};
    endfunction

    function automatic tb_bun_t m_bun();
        return {RegWriteM, MemWriteM, JumpM, JumpRegM, BranchM, ResultSrcM, RdM,
                AluResultM, WriteDataM, ImmExtM, PCPlus4M};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] ctl);
        ValidE     = v;
        AluResultE = alu;
        WriteDataE = alu ^ 32'hA5A5_0000;
        ImmExtE    = alu + 32'd1;
        PCPlus4E   = {alu[29:0], 2'b00};
        RdE        = alu[4:0];
        ResultSrcE = 2'b10;
        {RegWriteE, MemWriteE, JumpE, JumpRegE, BranchE} = ctl;
    endtask

    // One line per downstream transaction; held outputs must not move while stalled.
    always @(negedge CLK) begin
        tb_bun_t cur;
        tb_bun_t exp_b;
        cur = m_bun();
        if (RST) begin
            sb.delete();
            hold_prev = 1'b0;
        end else begin
            if (!ValidM)
                check_eq("bubble_ctl", {RegWriteM, MemWriteM, JumpM, JumpRegM, BranchM}, 5'b0);
            if (hold_prev)
                check_eq("hold_stable", {ValidM, cur}, prev_out);
            if (ValidM && ReadyM) begin
                check_eq("sb_occupancy", (sb.size() > 0), 1'b1);
                if (sb.size() > 0) begin
                    exp_b = sb.pop_front();
                    check_eq("sb_bundle", cur, exp_b);
                    $display("xfer out alu=%08h rd=%0d ctl=%05b", AluResultM, RdM, cur.ctl);
                end
            end
            if (FlushM) begin
                sb.delete();
            end else if (ValidE && ReadyE) begin
                sb.push_back(e_bun());
                n_up++;
            end
            hold_prev = ValidM && !ReadyM && !FlushM;
            prev_out  = {ValidM, cur};
        end
    end

    task automatic do_reset();
        RST = 1'b1;
        repeat (3) begin
            ValidE = 1'($urandom); ReadyM = 1'($urandom); FlushM = 1'($urandom);
            AluResultE = $urandom; WriteDataE = $urandom; ImmExtE = $urandom; PCPlus4E = $urandom;
            RdE = 5'($urandom); ResultSrcE = 2'($urandom);
            {RegWriteE, MemWriteE, JumpE, JumpRegE, BranchE} = 5'($urandom);
            tick();
        end
        check_eq("rst_valid", ValidM, 1'b0);
        check_eq("rst_bundle", m_bun(), '0);
        check_eq("rst_cnt", StallCnt, '0);
        drive(1'b0, 32'h0, 5'b0);
        FlushM = 1'b0;
        ReadyM = 1'b1;
        RST = 1'b0;
        #1;
        check_eq("rst_readyE", ReadyE, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int up0;
        do_reset();

        // Streaming at full rate.
        ReadyM = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h10 + 32'(i), 5'b11111);
            tick();
            check_eq("stream_valid", ValidM, 1'b1);
            check_eq("stream_alu", AluResultM, 32'h10 + 32'(i));
            check_eq("stream_rsrc", ResultSrcM, 2'b10);
        end
        drive(1'b0, 32'h0, 5'b11111);
        tick();
        tick();
        check_eq("stream_drain", sb.size(), 0);
        check_eq("stream_idle", ValidM, 1'b0);

        // Back-pressure.
        do_reset();
        ReadyM = 1'b0;
        drive(1'b1, 32'hDEADBEEF, 5'b00010);
        tick();
        up0 = n_up;
        drive(1'b1, 32'hCAFE0001, 5'b00001);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_hold", AluResultM, 32'hDEADBEEF);
        end
        check_eq("bp_cnt", StallCnt, 4'd5);
        check_eq("bp_readyE", ReadyE, 1'b0);
        check_eq("bp_extra", n_up - up0, EXTRA_ACCEPT);
        ReadyM = 1'b1;
        drive(1'b0, 32'h0, 5'b0);
        repeat (3) tick();
        check_eq("bp_drain", sb.size(), 0);
        check_eq("bp_cnt_keep", StallCnt, 4'd5);

        // Flush with a simultaneous downstream and upstream transfer.
        ReadyM = 1'b0;
        drive(1'b1, 32'h100, 5'b01000);
        tick();
        ReadyM = 1'b1;
        drive(1'b1, 32'h200, 5'b01000);
        FlushM = 1'b1;
        #1;
        check_eq("flush_readyE", ReadyE, 1'b1);
        tick();
        FlushM = 1'b0;
        drive(1'b0, 32'h0, 5'b0);
        check_eq("flush_valid", ValidM, 1'b0);
        check_eq("flush_memwr", MemWriteM, 1'b0);
        repeat (3) begin
            tick();
            check_eq("flush_gone", ValidM, 1'b0);
        end

        // Flush while stalled (skid full when present).
        ReadyM = 1'b0;
        drive(1'b1, 32'h300, 5'b01000);
        tick();
        drive(1'b1, 32'h400, 5'b01000);
        tick();
        tick();
        FlushM = 1'b1;
        tick();
        FlushM = 1'b0;
        drive(1'b0, 32'h0, 5'b0);
        ReadyM = 1'b1;
        check_eq("flush2_readyE", ReadyE, 1'b1);
        repeat (3) begin
            tick();
            check_eq("flush2_gone", ValidM, 1'b0);
        end
        check_eq("flush2_sb", sb.size(), 0);

        // Bubble gating.
        drive(1'b0, 32'h500, 5'b10100);
        tick();
        check_eq("bubble_regwr", RegWriteM, 1'b0);
        check_eq("bubble_jump", JumpM, 1'b0);
        check_eq("bubble_valid", ValidM, 1'b0);

        // Stall counter saturation.
        do_reset();
        ReadyM = 1'b0;
        drive(1'b1, 32'h600, 5'b00001);
        tick();
        drive(1'b0, 32'h0, 5'b0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14)
                check_eq("sat_cnt14", StallCnt, 4'd14);
        end
        check_eq("sat_cnt", StallCnt, 4'd15);
        ReadyM = 1'b1;
        repeat (2) tick();
        check_eq("sat_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
